vram_dblbuf: RTL and testbench

Double-buffered pixel store between the core's pixel writer (hh/vv/rgb332/color_ready/frame) and the 256x256 video timing generator.
- Replaces the ad-hoc frame-edge-clocked bank swap with one synchronous in the clk_sys domain.
- Bank swap is deferred to the start of display vertical blank, so no displayed frame tears.
- Produces aligned 8:8:8 RGB, HS, VS and DE for the VGA_* outputs.

---
 rtl/vram_pkg.sv | 25 ++
 rtl/vram_dp.sv | 25 ++
 rtl/vram_dblbuf.sv | 140 ++++++++++++++
 tb/tb_vram_dblbuf.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared types and helpers for the double-buffered video store.
package vram_pkg;

  localparam int unsigned HW_DEF = 8;
  localparam int unsigned VW_DEF = 8;
  localparam int unsigned AW     = HW_DEF + VW_DEF + 1;
  localparam int unsigned DEPTH  = 2 ** AW;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_t;

  // Bit replication keeps full-scale codes at 8'hFF and zero at 8'h00.
  function automatic logic [23:0] expand_rgb332(input rgb332_t p);
    return {p.r, p.r, p.r[2:1], p.g, p.g, p.g[2:1], p.b, p.b, p.b, p.b};
  endfunction

endpackage

// File: rtl/vram_dp.sv
// Simple dual-port pixel RAM: one write port, one ce-gated registered read port.
module vram_dp
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W = AW,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_sys,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // No reset on storage so it maps onto block RAM.
  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vram_dblbuf.sv
// Double-buffered 256x256 pixel store with vblank-deferred bank swap.
// Optional saturating overrun counter port under `VRAM_OVERRUN_CNT_EN.
module vram_dblbuf
  import vram_pkg::*;
#(
  parameter int unsigned HW   = HW_DEF,
  parameter int unsigned VW   = VW_DEF,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            ce_pix,
  input  logic            wr_en,
  input  logic [HW-1:0]   wr_x,
  input  logic [VW-1:0]   wr_y,
  input  logic [7:0]      wr_data,
  input  logic            frame,
  input  logic [8:0]      hcount,
  input  logic [8:0]      vcount,
  input  logic            hs_in,
  input  logic            vs_in,
  input  logic            hb_in,
  input  logic            vb_in,
  output logic [7:0]      r_out,
  output logic [7:0]      g_out,
  output logic [7:0]      b_out,
  output logic            hs_out,
  output logic            vs_out,
  output logic            de_out,
`ifdef VRAM_OVERRUN_CNT_EN
  output logic [CNTW-1:0] overrun_cnt,
`endif
  output logic            front_bank,
  output logic            swap_pending
);

  localparam int unsigned ADDR_W = HW + VW + 1;

  swap_state_t       state, state_d;
  logic              fb_d;
  logic              frame_q, vb_q;
  logic              frame_rise, vb_rise;
  logic              de0, hs0, vs0, win0;
  logic              in_win;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [7:0]        rd_data;
  rgb332_t           pix;
  logic [23:0]       rgb24;

  assign frame_rise   = frame & ~frame_q;
  assign vb_rise      = ce_pix & vb_in & ~vb_q;
  assign swap_pending = (state == PENDING);

  // Swap FSM state register, bank register and edge detectors.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      front_bank <= 1'b0;
      frame_q    <= 1'b0;
      vb_q       <= 1'b0;
    end else begin
      state      <= state_d;
      front_bank <= fb_d;
      frame_q    <= frame;
      if (ce_pix) vb_q <= vb_in;
    end
  end

  // A frame edge arriving with the applying vblank keeps the request alive.
  always_comb begin
    state_d = state;
    fb_d    = front_bank;
    case (state)
      IDLE: begin
        if (frame_rise) state_d = PENDING;
      end
      PENDING: begin
        if (vb_rise) begin
          fb_d = ~front_bank;
          if (!frame_rise) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef VRAM_OVERRUN_CNT_EN
  logic overrun;
  assign overrun = (state == PENDING) & frame_rise;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      overrun_cnt <= '0;
    end else if (overrun && (overrun_cnt != {CNTW{1'b1}})) begin
      overrun_cnt <= overrun_cnt + CNTW'(1);
    end
  end
`endif

  // Writes always target the bank that is not being displayed.
  assign wr_addr = {~front_bank, wr_y, wr_x};
  assign rd_addr = {front_bank, vcount[VW-1:0], hcount[HW-1:0]};
  assign in_win  = ((hcount >> HW) == 9'd0) && ((vcount >> VW) == 9'd0);

  vram_dp #(
    .ADDR_W (ADDR_W),
    .DATA_W (8)
  ) u_mem (
    .clk_sys (clk_sys),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (ce_pix),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Timing stage aligned with the registered RAM read.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      de0  <= 1'b0;
      hs0  <= 1'b0;
      vs0  <= 1'b0;
      win0 <= 1'b0;
    end else if (ce_pix) begin
      de0  <= ~(hb_in | vb_in);
      hs0  <= hs_in;
      vs0  <= vs_in;
      win0 <= in_win;
    end
  end

  assign pix   = rgb332_t'(rd_data);
  assign rgb24 = (de0 && win0) ? expand_rgb332(pix) : 24'd0;
  assign {r_out, g_out, b_out} = rgb24;
  assign de_out = de0;
  assign hs_out = hs0;
  assign vs_out = vs0;

endmodule

// File: tb/tb_vram_dblbuf.sv
// Directed bench for vram_dblbuf; overrun counter checks only with VRAM_OVERRUN_CNT_EN.
module tb_vram_dblbuf;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       ce_pix = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_x = '0, wr_y = '0, wr_data = '0;
  logic       frame = 1'b0;
  logic [8:0] hcount = '0, vcount = '0;
  logic       hs_in = 1'b0, vs_in = 1'b0, hb_in = 1'b0, vb_in = 1'b0;
  logic [7:0] r_out, g_out, b_out;
  logic       hs_out, vs_out, de_out, front_bank, swap_pending;
`ifdef VRAM_OVERRUN_CNT_EN
  logic [1:0] overrun_cnt;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  logic fb_model = 1'b0;

  vram_dblbuf #(.HW(8), .VW(8), .CNTW(2)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ce_pix       (ce_pix),
    .wr_en        (wr_en),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_data      (wr_data),
    .frame        (frame),
    .hcount       (hcount),
    .vcount       (vcount),
    .hs_in        (hs_in),
    .vs_in        (vs_in),
    .hb_in        (hb_in),
    .vb_in        (vb_in),
    .r_out        (r_out),
    .g_out        (g_out),
    .b_out        (b_out),
    .hs_out       (hs_out),
    .vs_out       (vs_out),
    .de_out       (de_out),
`ifdef VRAM_OVERRUN_CNT_EN
    .overrun_cnt  (overrun_cnt),
`endif
    .front_bank   (front_bank),
    .swap_pending (swap_pending)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic write_px(input logic [7:0] x, input logic [7:0] y, input logic [7:0] d);
    wr_x = x; wr_y = y; wr_data = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_swap();
    frame = 1'b1; tick();
    frame = 1'b0; vb_in = 1'b1; tick();
    vb_in = 1'b0; tick();
    fb_model = ~fb_model;
  endtask

  task automatic read_px(input logic [8:0] h, input logic [8:0] v, input logic hb,
                         input logic hs, input logic vs);
    hcount = h; vcount = v; hb_in = hb; vb_in = 1'b0; hs_in = hs; vs_in = vs;
    tick();
  endtask

  task automatic test_reset();
    tick(); tick();
    total_cnt++;
    if ({r_out, g_out, b_out, hs_out, vs_out, de_out} !== 27'd0)
      $display("FAIL reset_outs: got %h want 0", {r_out, g_out, b_out, hs_out, vs_out, de_out});
    else pass_cnt++;
    total_cnt++;
    if ({front_bank, swap_pending} !== 2'b00)
      $display("FAIL reset_fsm: got %b want 00", {front_bank, swap_pending});
    else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_swap();
    write_px(8'd5, 8'd7, 8'hE0);
    frame = 1'b1; tick();
    total_cnt++;
    if ({front_bank, swap_pending} !== 2'b01)
      $display("FAIL t1_pending: got %b want 01", {front_bank, swap_pending});
    else pass_cnt++;
    frame = 1'b0; vb_in = 1'b1; tick();
    total_cnt++;
    if ({front_bank, swap_pending} !== 2'b10)
      $display("FAIL t1_swapped: got %b want 10", {front_bank, swap_pending});
    else pass_cnt++;
    vb_in = 1'b0; tick();
    fb_model = 1'b1;
    read_px(9'd5, 9'd7, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if ({r_out, g_out, b_out, de_out} !== {24'hFF0000, 1'b1})
      $display("FAIL t1_pix: got %h want %h", {r_out, g_out, b_out, de_out}, {24'hFF0000, 1'b1});
    else pass_cnt++;
    // Outputs must hold while ce_pix is low.
    ce_pix = 1'b0;
    read_px(9'd0, 9'd0, 1'b1, 1'b1, 1'b1);
    total_cnt++;
    if ({r_out, g_out, b_out, hs_out, vs_out, de_out} !== {24'hFF0000, 3'b001})
      $display("FAIL t1_hold: got %h want %h", {r_out, g_out, b_out, hs_out, vs_out, de_out},
               {24'hFF0000, 3'b001});
    else pass_cnt++;
    ce_pix = 1'b1;
  endtask

  task automatic test_deferred_swap();
    write_px(8'd0, 8'd0, 8'hA9);
    hcount = 9'd100; vcount = 9'd50;
    frame = 1'b1; tick();
    frame = 1'b0; tick(); tick(); tick();
    total_cnt++;
    if ({front_bank, swap_pending} !== 2'b11)
      $display("FAIL t2_wait: got %b want 11", {front_bank, swap_pending});
    else pass_cnt++;
    ce_pix = 1'b0; vb_in = 1'b1; tick();
    total_cnt++;
    if ({front_bank, swap_pending} !== 2'b11)
      $display("FAIL t2_no_ce: got %b want 11", {front_bank, swap_pending});
    else pass_cnt++;
    ce_pix = 1'b1; tick();
    total_cnt++;
    if ({front_bank, swap_pending} !== 2'b00)
      $display("FAIL t2_swap: got %b want 00", {front_bank, swap_pending});
    else pass_cnt++;
    vb_in = 1'b0; tick();
    fb_model = 1'b0;
    read_px(9'd0, 9'd0, 1'b0, 1'b1, 1'b0);
    total_cnt++;
    if ({r_out, g_out, b_out, hs_out, vs_out, de_out} !== {24'hB64955, 3'b101})
      $display("FAIL t2_pix: got %h want %h", {r_out, g_out, b_out, hs_out, vs_out, de_out},
               {24'hB64955, 3'b101});
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    frame = 1'b1; tick();
    frame = 1'b0; tick();
    frame = 1'b1; tick();
    frame = 1'b0; tick();
    total_cnt++;
    if ({front_bank, swap_pending} !== 2'b01)
      $display("FAIL t3_pending: got %b want 01", {front_bank, swap_pending});
    else pass_cnt++;
`ifdef VRAM_OVERRUN_CNT_EN
    total_cnt++;
    if (overrun_cnt !== 2'd1) $display("FAIL t3_cnt: got %0d want 1", overrun_cnt);
    else pass_cnt++;
`endif
    vb_in = 1'b1; tick(); vb_in = 1'b0; tick();
    vb_in = 1'b1; tick(); vb_in = 1'b0; tick();
    total_cnt++;
    if ({front_bank, swap_pending} !== 2'b10)
      $display("FAIL t3_one_toggle: got %b want 10", {front_bank, swap_pending});
    else pass_cnt++;
    fb_model = 1'b1;
  endtask

  task automatic test_same_cycle();
    frame = 1'b1; vb_in = 1'b1; tick();
    total_cnt++;
    if ({front_bank, swap_pending} !== 2'b11)
      $display("FAIL t_idle_both: got %b want 11", {front_bank, swap_pending});
    else pass_cnt++;
    frame = 1'b0; vb_in = 1'b0; tick();
    frame = 1'b1; vb_in = 1'b1; tick();
    total_cnt++;
    if ({front_bank, swap_pending} !== 2'b01)
      $display("FAIL t_pend_both: got %b want 01", {front_bank, swap_pending});
    else pass_cnt++;
`ifdef VRAM_OVERRUN_CNT_EN
    total_cnt++;
    if (overrun_cnt !== 2'd2) $display("FAIL t_pend_cnt: got %0d want 2", overrun_cnt);
    else pass_cnt++;
`endif
    frame = 1'b0; vb_in = 1'b0; tick();
    vb_in = 1'b1; tick(); vb_in = 1'b0; tick();
    total_cnt++;
    if ({front_bank, swap_pending} !== 2'b10)
      $display("FAIL t_pend_apply: got %b want 10", {front_bank, swap_pending});
    else pass_cnt++;
    fb_model = 1'b1;
  endtask

  task automatic test_window();
    write_px(8'd9, 8'd9, 8'hFF);
    do_swap();
    read_px(9'd300, 9'd9, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if ({r_out, g_out, b_out, de_out} !== {24'h0, 1'b1})
      $display("FAIL t4_hwin: got %h want %h", {r_out, g_out, b_out, de_out}, {24'h0, 1'b1});
    else pass_cnt++;
    read_px(9'd9, 9'd9, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if ({r_out, g_out, b_out, de_out} !== 25'd0)
      $display("FAIL t4_blank: got %h want 0", {r_out, g_out, b_out, de_out});
    else pass_cnt++;
    read_px(9'd9, 9'd9, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if ({r_out, g_out, b_out, de_out} !== {24'hFFFFFF, 1'b1})
      $display("FAIL t4_in: got %h want %h", {r_out, g_out, b_out, de_out}, {24'hFFFFFF, 1'b1});
    else pass_cnt++;
    read_px(9'd9, 9'd265, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if ({r_out, g_out, b_out, de_out} !== {24'h0, 1'b1})
      $display("FAIL t4_vwin: got %h want %h", {r_out, g_out, b_out, de_out}, {24'h0, 1'b1});
    else pass_cnt++;
  endtask

  task automatic test_write_on_swap();
    write_px(8'd3, 8'd3, 8'h03);
    frame = 1'b1; tick();
    frame = 1'b0; tick();
    vb_in = 1'b1; wr_x = 8'd3; wr_y = 8'd3; wr_data = 8'h1C; wr_en = 1'b1; tick();
    wr_en = 1'b0; vb_in = 1'b0; tick();
    fb_model = ~fb_model;
    read_px(9'd3, 9'd3, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if ({r_out, g_out, b_out, de_out} !== {24'h00FF00, 1'b1})
      $display("FAIL t5_pix: got %h want %h", {r_out, g_out, b_out, de_out}, {24'h00FF00, 1'b1});
    else pass_cnt++;
  endtask

`ifdef VRAM_OVERRUN_CNT_EN
  task automatic test_overrun_sat();
    frame = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      frame = 1'b0; tick();
      frame = 1'b1; tick();
    end
    frame = 1'b0; tick();
    total_cnt++;
    if (overrun_cnt !== 2'd3) $display("FAIL t3_sat: got %0d want 3", overrun_cnt);
    else pass_cnt++;
    vb_in = 1'b1; tick(); vb_in = 1'b0; tick();
    fb_model = ~fb_model;
  endtask
`endif

  task automatic test_reset_pending();
    write_px(8'd1, 8'd1, 8'hFF);
    do_swap();
    if (fb_model == 1'b0) begin
      write_px(8'd1, 8'd1, 8'hFF);
      do_swap();
    end
    read_px(9'd1, 9'd1, 1'b0, 1'b1, 1'b1);
    frame = 1'b1; tick();
    total_cnt++;
    if ({front_bank, swap_pending, r_out, de_out} !== {2'b11, 8'hFF, 1'b1})
      $display("FAIL t6_pre: got %h want %h", {front_bank, swap_pending, r_out, de_out},
               {2'b11, 8'hFF, 1'b1});
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if ({front_bank, swap_pending} !== 2'b00)
      $display("FAIL t6_fsm: got %b want 00", {front_bank, swap_pending});
    else pass_cnt++;
    total_cnt++;
    if ({r_out, g_out, b_out, hs_out, vs_out, de_out} !== 27'd0)
      $display("FAIL t6_outs: got %h want 0", {r_out, g_out, b_out, hs_out, vs_out, de_out});
    else pass_cnt++;
`ifdef VRAM_OVERRUN_CNT_EN
    total_cnt++;
    if (overrun_cnt !== 2'd0) $display("FAIL t6_cnt: got %0d want 0", overrun_cnt);
    else pass_cnt++;
`endif
    frame = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_swap();
    test_deferred_swap();
    test_overrun();
    test_same_cycle();
    test_window();
    test_write_on_swap();
`ifdef VRAM_OVERRUN_CNT_EN
    test_overrun_sat();
`endif
    test_reset_pending();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
